pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MC_TIMEOUT, default 64: EX multi-cycle watchdog limit in cycles, legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 stallreq_from_id  input  1  ID hazard (load-use) stall request; level, combinational from ID.
REQ-005 stallreq_from_ex  input  1  EX single-cycle stall request; level.
REQ-006 mc_start_i  input  1  one-cycle pulse: EX issued a multi-cycle op (div/madd).
REQ-007 mc_done_i  input  1  one-cycle pulse: multi-cycle result valid.
REQ-008 flush_req_i  input  1  exception/redirect flush request; one-cycle pulse.
REQ-009 stall  output  6  per-stage hold vector: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB; 1 = Stop.
REQ-010 flush  output  1  registered flush to all pipeline registers.
REQ-011 mc_busy_o  output  1  high while in MC_BUSY.
REQ-012 mc_timeout_o  output  1  one-cycle pulse on watchdog expiry; present only with PIPE_CTRL_WATCHDOG_EN.

Function
REQ-013 The FSM SHALL have states IDLE, MC_BUSY and FLUSH, in a registered state register.
REQ-014 stall SHALL be combinational from state and inputs; flush SHALL be registered, i.e. asserted for exactly one cycle, the cycle after flush_req_i.
REQ-015 In IDLE, stall SHALL be 6'b001111 if stallreq_from_ex, else 6'b000111 if stallreq_from_id, else 6'b000000; EX outranks ID.
REQ-016 In IDLE, mc_start_i SHALL move the FSM to MC_BUSY on the next edge; stall SHALL be 6'b001111 in the same cycle as mc_start_i.
REQ-017 In MC_BUSY, stall SHALL be 6'b001111 every cycle; ID/EX therefore holds its contents and does not insert a bubble.
REQ-018 In MC_BUSY, mc_done_i SHALL return the FSM to IDLE; stall SHALL be 6'b000000 in the mc_done_i cycle unless an ID or EX request is active (REQ-015 priority).
REQ-019 flush_req_i SHALL override everything: the FSM enters FLUSH on the next edge from any state, abandoning MC_BUSY; stall SHALL be 6'b000000 in the request cycle.
REQ-020 FLUSH SHALL last exactly one cycle with flush=1 and stall=6'b000000, then go to IDLE; mc_start_i in that cycle SHALL be ignored.
REQ-021 mc_done_i while in IDLE or FLUSH SHALL be ignored.
REQ-022 mc_start_i and mc_done_i asserted in the same MC_BUSY cycle SHALL be treated as done followed by a new start: the FSM stays in MC_BUSY and the watchdog counter reloads.
REQ-023 stall SHALL always be of the contiguous form 0...01...1, lowest bit first; no other pattern is legal.

Reset
REQ-024 When rst=0, asynchronously: state=IDLE, flush=0, counter=0, mc_timeout_o=0; stall=6'b000000 and mc_busy_o=0 while reset is held.
REQ-025 Reset asserted mid-MC_BUSY or mid-FLUSH SHALL abort the operation; no flush pulse is produced after release.

Configuration
REQ-026 With PIPE_CTRL_WATCHDOG_EN defined: an 8-bit counter clears on MC_BUSY entry and increments each MC_BUSY cycle; on reaching MC_TIMEOUT-1 without mc_done_i the FSM enters FLUSH and mc_timeout_o pulses for one cycle; mc_done_i in the expiry cycle takes priority, so no timeout occurs.
REQ-027 Without PIPE_CTRL_WATCHDOG_EN: no counter and no mc_timeout_o port; MC_BUSY waits indefinitely for mc_done_i or flush_req_i.

Structure
REQ-028 The stall-vector constants (STALL_NONE 6'b000000, STALL_ID 6'b000111, STALL_EX 6'b001111), the Stop/NoStop values and the state encoding SHALL reside in the shared defines header.
REQ-029 The block SHALL be a single module with no sub-modules; the watchdog is inline logic.

Verification
REQ-030 stallreq_from_id=1 for 1 cycle in IDLE -> stall=6'b000111 that cycle, 6'b000000 the next; flush stays 0.
REQ-031 stallreq_from_id=1 and stallreq_from_ex=1 together -> stall=6'b001111.
REQ-032 mc_start_i at cycle 0, mc_done_i at cycle 10 -> stall=6'b001111 for cycles 0..9, mc_busy_o=1 for cycles 1..10, stall=6'b000000 at cycle 10.
REQ-033 flush_req_i at cycle 5 of MC_BUSY -> flush=1 at cycle 6 only, stall=6'b000000 from cycle 5, IDLE at cycle 7; a later mc_done_i is ignored.
REQ-034 With PIPE_CTRL_WATCHDOG_EN and MC_TIMEOUT=8: mc_start_i with no done -> mc_timeout_o pulses after 8 MC_BUSY cycles, flush=1 the next cycle, then IDLE.
REQ-035 rst driven low asynchronously between clock edges during MC_BUSY -> stall=6'b000000 and mc_busy_o=0 immediately; after release the FSM is in IDLE with flush=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall vectors,
// Stop/NoStop values, FSM state encoding and the request-priority helper.
package pipe_ctrl_pkg;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // Bit order: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB.
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MC_BUSY = 2'd1,
      FLUSH   = 2'd2
   } state_t;

   // EX outranks ID; every result is a contiguous low-order run of Stop bits.
   function automatic logic [5:0] stall_for(input logic from_id, input logic from_ex);
      if (from_ex == STOP)
         return STALL_EX;
      else if (from_id == STOP)
         return STALL_ID;
      else
         return STALL_NONE;
   endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with multi-cycle EX tracking.
// Optional multi-cycle watchdog enabled by defining PIPE_CTRL_WATCHDOG_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MC_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       stallreq_from_id,
   input  logic       stallreq_from_ex,
   input  logic       mc_start_i,
   input  logic       mc_done_i,
   input  logic       flush_req_i,
   output logic [5:0] stall,
   output logic       flush,
   output logic       mc_busy_o
`ifdef PIPE_CTRL_WATCHDOG_EN
   ,
   output logic       mc_timeout_o
`endif
);

   if (MC_TIMEOUT < 2 || MC_TIMEOUT > 255) begin : g_bad_timeout
      $error("pipe_ctrl: MC_TIMEOUT must be within 2..255");
   end

   state_t     state_reg, state_next;
   logic       flush_reg, flush_next;
   logic [5:0] stall_next;

`ifdef PIPE_CTRL_WATCHDOG_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(MC_TIMEOUT - 1);
   logic [7:0] count_reg, count_next;
   logic       expire;
`endif

   always_comb begin
      state_next = state_reg;
      stall_next = STALL_NONE;
`ifdef PIPE_CTRL_WATCHDOG_EN
      count_next = count_reg;
      expire     = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (flush_req_i) begin
               state_next = FLUSH;
            end else if (mc_start_i) begin
               state_next = MC_BUSY;
               stall_next = STALL_EX;
`ifdef PIPE_CTRL_WATCHDOG_EN
               count_next = 8'd0;
`endif
            end else begin
               stall_next = stall_for(stallreq_from_id, stallreq_from_ex);
            end
         end
         MC_BUSY: begin
            if (flush_req_i) begin
               state_next = FLUSH;
            end else if (mc_done_i && mc_start_i) begin
               // Back-to-back op: finish the old one and immediately start anew.
               stall_next = STALL_EX;
`ifdef PIPE_CTRL_WATCHDOG_EN
               count_next = 8'd0;
`endif
            end else if (mc_done_i) begin
               state_next = IDLE;
               stall_next = stall_for(stallreq_from_id, stallreq_from_ex);
            end else begin
               stall_next = STALL_EX;
`ifdef PIPE_CTRL_WATCHDOG_EN
               if (count_reg == TIMEOUT_LAST) begin
                  expire     = 1'b1;
                  state_next = FLUSH;
               end else begin
                  count_next = count_reg + 8'd1;
               end
`endif
            end
         end
         FLUSH: begin
            state_next = flush_req_i ? FLUSH : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      flush_next = (state_next == FLUSH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         flush_reg <= 1'b0;
`ifdef PIPE_CTRL_WATCHDOG_EN
         count_reg <= 8'd0;
`endif
      end else begin
         state_reg <= state_next;
         flush_reg <= flush_next;
`ifdef PIPE_CTRL_WATCHDOG_EN
         count_reg <= count_next;
`endif
      end
   end

   // Level requests may be active during reset; keep the pipeline running then.
   assign stall     = rst ? stall_next : STALL_NONE;
   assign flush     = flush_reg;
   assign mc_busy_o = (state_reg == MC_BUSY);
`ifdef PIPE_CTRL_WATCHDOG_EN
   assign mc_timeout_o = expire;
`endif

endmodule
